// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared UART receive types, link constants and register addresses
package uart_rx_pkg;

  // Link settings shared with the transmitter
  localparam int UART_CLK_FREQ  = 50_000_000;
  localparam int UART_BAUD_RATE = 115_200;

  // Memory-mapped locations decoded by data_mem
  localparam logic [31:0] UART_RX_DATA_ADDR = 32'h0000_1004;
  localparam logic [31:0] UART_RX_STAT_ADDR = 32'h0000_1008;

  // Receiver FSM states
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line plus memory-mapped read port of the UART receiver
interface uart_rx_if;
  logic       rx;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] rd_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  // Bus side (data_mem / line driver)
  modport master (
    output rx, rd_en, err_clr,
    input  rd_data, rx_valid, frame_err, overrun
  );

  // Receiver side
  modport slave (
    input  rx, rd_en, err_clr,
    output rd_data, rx_valid, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word fall-through receive buffer
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  // A pop on a full buffer frees the slot, so the same-cycle push still lands
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  // Storage array; contents are don't-care until the count covers them
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 LSB-first serial receiver with buffered memory-mapped read port
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ     = UART_CLK_FREQ,
  parameter int BAUD_RATE    = UART_BAUD_RATE,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
  parameter int FIFO_DEPTH   = 4
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e     state_q, state_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          rx_meta_q, rx_s_q;
  logic          frame_err_q, overrun_q;
  logic          push;
  logic          frame_set;
  logic          overrun_set;
  logic          fifo_empty;
  logic          fifo_full;

  // Two-flop synchroniser, preset to the idle-high line level
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receiver state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RX_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
    end
  end

  // Frame sequencing: half-bit start qualification, then mid-bit sampling
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    push       = 1'b0;
    frame_set  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rx_s_q) begin
          state_d    = RX_START;
          baud_cnt_d = BAUD_HALF;
        end
      end
      RX_START: begin
        if (baud_cnt_q == '0) begin
          if (!rx_s_q) begin
            state_d    = RX_DATA;
            baud_cnt_d = BAUD_FULL;
            bit_idx_d  = '0;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - CW'(1);
        end
      end
      RX_DATA: begin
        if (baud_cnt_q == '0) begin
          shift_d    = {rx_s_q, shift_q[7:1]};
          baud_cnt_d = BAUD_FULL;
          if (bit_idx_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - CW'(1);
        end
      end
      RX_STOP: begin
        if (baud_cnt_q == '0) begin
          // Leave immediately so a start bit right after the stop bit is caught
          state_d = RX_IDLE;
          if (rx_s_q) push = 1'b1;
          else        frame_set = 1'b1;
        end else begin
          baud_cnt_d = baud_cnt_q - CW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // A full buffer only drops the byte when no pop frees a slot this cycle
  assign overrun_set = push && fifo_full && !bus.rd_en;

  // Sticky error flags; a set in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (frame_set)        frame_err_q <= 1'b1;
      else if (bus.err_clr) frame_err_q <= 1'b0;
      if (overrun_set)      overrun_q   <= 1'b1;
      else if (bus.err_clr) overrun_q   <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shift_q),
    .pop       (bus.rd_en),
    .head      (bus.rd_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign bus.rx_valid  = !fifo_empty;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule
